clock_divider_ctrl: RTL and testbench

//  Sequences a programmable clock-divide datapath: counts clkin cycles to make a divided

---
 rtl/clk_ctrl_pkg.sv | 18 +
 rtl/clock_divider_ctrl_period_counter.sv | 47 ++++
 rtl/clock_divider_ctrl.sv | 114 +++++++++++
 tb/tb_clock_divider_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and helpers for the clock divider controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } ctrl_state_t;

  // Smallest ratio that still produces a low and a high phase.
  localparam int unsigned MIN_DIV = 2;

  // Requested ratios of 0 or 1 are meaningless; force them up to MIN_DIV.
  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/clock_divider_ctrl_period_counter.sv
// Period counter: counts 0..N-1 and produces registered phase/tick that line up
// with the count value held in the same cycle.
module period_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             clear,       // force count to 0 next cycle
  input  logic             enable,      // advance count (wraps after N-1)
  input  logic [DIV_W-1:0] div,         // N in force this cycle
  input  logic [DIV_W-1:0] div_nxt,     // N in force next cycle
  input  logic             active_nxt,  // counting next cycle
  output logic [DIV_W-1:0] cnt,
  output logic             last,        // cnt == N-1 this cycle
  output logic             phase_q,
  output logic             tick_q
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_d, tick_d;

  // Next count and the phase/tick decode of that next count.
  always_comb begin
    last    = (cnt_q == (div - DIV_W'(1)));
    cnt_d   = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = last ? '0 : (cnt_q + DIV_W'(1));
    phase_d = active_nxt && (cnt_d >= (div_nxt >> 1));
    tick_d  = active_nxt && (cnt_d == (div_nxt - DIV_W'(1)));
  end

  // Count and decoded-output registers.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/clock_divider_ctrl.sv
// Clock divider controller: IDLE/RUN/STEP sequencing, ratio update handshake
// applied only at period boundaries, and a completed-period counter.
module clock_divider_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int PCNT_W      = 16
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic              clk_phase,
  output logic              tick,
  output logic              busy,
  output logic [DIV_W-1:0]  cur_div,
  output logic [PCNT_W-1:0] period_count
);

  ctrl_state_t       state_q, state_d;
  logic              pend_v_q, pend_v_d;
  logic [DIV_W-1:0]  pend_div_q, pend_div_d;
  logic [DIV_W-1:0]  cur_div_q, cur_div_d;
  logic [PCNT_W-1:0] period_count_q, period_count_d;
  logic              busy_q, busy_d;

  logic              cnt_last, boundary, cfg_hs, cnt_clear, cnt_en;
  logic [DIV_W-1:0]  cnt;

  period_counter #(.DIV_W(DIV_W)) u_cnt (
    .clkin      (clkin),
    .reset      (reset),
    .clear      (cnt_clear),
    .enable     (cnt_en),
    .div        (cur_div_q),
    .div_nxt    (cur_div_d),
    .active_nxt (busy_d),
    .cnt        (cnt),
    .last       (cnt_last),
    .phase_q    (clk_phase),
    .tick_q     (tick)
  );

  // FSM next state, ratio pipeline and period accounting.
  always_comb begin
    state_d        = state_q;
    pend_v_d       = pend_v_q;
    pend_div_d     = pend_div_q;
    cur_div_d      = cur_div_q;
    period_count_d = period_count_q;
    boundary       = (state_q != IDLE) && cnt_last;
    cfg_hs         = cfg_valid && !pend_v_q;

    unique case (state_q)
      IDLE: begin
        if (run)       state_d = RUN;
        else if (step) state_d = STEP;
      end
      RUN: begin
        if (boundary && !run) state_d = IDLE;
      end
      STEP: begin
        if (boundary) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (boundary) period_count_d = period_count_q + PCNT_W'(1);

    // A pending ratio takes effect between periods so no period is ever split.
    if (pend_v_q && ((state_q == IDLE) || boundary)) begin
      cur_div_d = pend_div_q;
      pend_v_d  = 1'b0;
    end
    // Capture only when nothing is pending, so the two branches never overlap.
    if (cfg_hs) begin
      pend_div_d = DIV_W'(clamp_div(32'(cfg_div)));
      pend_v_d   = 1'b1;
    end

    busy_d    = (state_d != IDLE);
    cnt_en    = (state_q != IDLE);
    cnt_clear = (state_q == IDLE) || (state_d == IDLE);
  end

  // Control and configuration registers.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pend_v_q       <= 1'b0;
      pend_div_q     <= DIV_W'(DEFAULT_DIV);
      cur_div_q      <= DIV_W'(DEFAULT_DIV);
      period_count_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_v_q       <= pend_v_d;
      pend_div_q     <= pend_div_d;
      cur_div_q      <= cur_div_d;
      period_count_q <= period_count_d;
      busy_q         <= busy_d;
    end
  end

  assign cfg_ready    = !pend_v_q;
  assign busy         = busy_q;
  assign cur_div      = cur_div_q;
  assign period_count = period_count_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Randomized bench for clock_divider_ctrl against a period-level reference model.
module tb_clock_divider_ctrl;

  logic        clkin = 1'b0;
  logic        reset;
  logic        run, step, cfg_valid;
  logic [7:0]  cfg_div;
  logic        cfg_ready, clk_phase, tick, busy;
  logic [7:0]  cur_div;
  logic [15:0] period_count;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: "in a period or not", position within the period,
  // the ratio in force, one pending ratio slot and the completed-period total.
  bit m_busy, m_step_mode, m_pend_v;
  int m_pos, m_n, m_pend, m_pc;

  always #5 clkin = ~clkin;

  clock_divider_ctrl #(.DIV_W(8), .DEFAULT_DIV(4), .PCNT_W(16)) dut (
    .clkin        (clkin),
    .reset        (reset),
    .run          (run),
    .step         (step),
    .cfg_valid    (cfg_valid),
    .cfg_div      (cfg_div),
    .cfg_ready    (cfg_ready),
    .clk_phase    (clk_phase),
    .tick         (tick),
    .busy         (busy),
    .cur_div      (cur_div),
    .period_count (period_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_step_mode = 0; m_pend_v = 0;
    m_pos = 0; m_n = 4; m_pend = 4; m_pc = 0;
  endtask

  // Advance the model by one clkin edge using the inputs that were present.
  task automatic model_step(input bit r, input bit s, input bit v, input int d);
    bit last;
    int n_next;
    bit pv_next;
    last    = m_busy && (m_pos == m_n - 1);
    n_next  = m_n;
    pv_next = m_pend_v;
    if (m_pend_v && (!m_busy || last)) begin
      n_next  = m_pend;
      pv_next = 0;
    end
    if (v && !m_pend_v) begin
      m_pend  = (d < 2) ? 2 : d;
      pv_next = 1;
    end
    if (!m_busy) begin
      if (r || s) begin
        m_busy = 1; m_step_mode = !r; m_pos = 0;
      end
    end else if (last) begin
      m_pc  = (m_pc + 1) % 65536;
      m_pos = 0;
      if (m_step_mode || !r) m_busy = 0;
    end else begin
      m_pos++;
    end
    m_n      = n_next;
    m_pend_v = pv_next;
  endtask

  task automatic check_outputs();
    chk("phase",  int'(clk_phase),    (m_busy && (m_pos >= m_n / 2)) ? 1 : 0);
    chk("tick",   int'(tick),         (m_busy && (m_pos == m_n - 1)) ? 1 : 0);
    chk("busy",   int'(busy),         int'(m_busy));
    chk("curdiv", int'(cur_div),      m_n);
    chk("pcount", int'(period_count), m_pc);
    chk("ready",  int'(cfg_ready),    m_pend_v ? 0 : 1);
  endtask

  task automatic cyc(input bit r, input bit s, input bit v, input int d);
    run = r; step = s; cfg_valid = v; cfg_div = d[7:0];
    @(posedge clkin);
    model_step(r, s, v, d);
    #1;
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && busy; i++) cyc(0, 0, 0, 0);
    chk("drain_idle", int'(busy), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, int'(clk_phase), 0);
    chk({tag, "_tick"},  int'(tick), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_cur"},   int'(cur_div), 4);
    chk({tag, "_pc"},    int'(period_count), 0);
    chk({tag, "_rdy"},   int'(cfg_ready), 1);
  endtask

  initial begin
    run = 0; step = 0; cfg_valid = 0; cfg_div = 0;
    reset = 1;
    model_reset();
    #23;
    chk_reset_vals("rst");
    reset = 0;
    #10;

    // Free run at the default ratio: 12 counted cycles -> 3 periods.
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pc_after12", int'(period_count), 3);
    drain();

    // Ratio change in IDLE, then run at N=5.
    cyc(0, 0, 1, 5);
    cyc(0, 0, 0, 0);
    chk("cur5", int'(cur_div), 5);
    for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0);   // offer at cnt=1 next
    cyc(1, 0, 1, 6);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 9);     // second offer stalls
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0);
    drain();

    // Single step with extra step pulses while busy.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    drain();

    // Ratio 0 clamps to 2.
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("clamp0", int'(cur_div), 2);
    cyc(0, 0, 1, 8);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);     // drop run mid-period
    drain();

    // Random traffic.
    begin
      bit r;
      r = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) r = !r;
        cyc(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 12)));
      end
    end

    // Asynchronous reset in the middle of a period.
    drain();
    cyc(0, 0, 1, 4);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    #3;
    reset = 1;
    #1;
    model_reset();
    chk_reset_vals("arst");
    @(negedge clkin);
    chk_reset_vals("arst_hold");
    reset = 0;
    run = 0;
    #7;
    for (int i = 0; i < 1000; i++)
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 5) == 0), int'($urandom_range(0, 10)));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
